// File: rtl/encoder_layer_1_attention_self_value_weight_sink_if.sv
// Value-weight sink bus: write-side stream (data_in/valid/ready) plus the ROM-style read port.
// The master modport is the producer/consumer side; the slave modport is the sink itself.
interface encoder_layer_1_attention_self_value_weight_sink_if #(
    parameter int DATA_W = 16,
    parameter int AWIDTH = 6
);
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic              rd_valid;
    logic [AWIDTH-1:0] rd_addr;
    logic              rd_ce;
    logic [DATA_W-1:0] rd_q;
    logic              rd_release;

    modport master (
        output data_in, data_in_valid, rd_addr, rd_ce, rd_release,
        input  data_in_ready, rd_valid, rd_q
    );

    modport slave (
        input  data_in, data_in_valid, rd_addr, rd_ce, rd_release,
        output data_in_ready, rd_valid, rd_q
    );
endinterface

// File: rtl/encoder_layer_1_attention_self_value_weight_sink.sv
// Ping-pong tensor sink: packs stream beats into two RAM banks and serves a full bank via a 2-stage read port.
// Optional sticky protocol checker enabled by ENCODER_LAYER_1_VALUE_WEIGHT_SINK_ERR_EN.
module encoder_layer_1_attention_self_value_weight_sink #(
    parameter int VALUE_WEIGHT_TENSOR_SIZE_DIM_0 = 32,
    parameter int VALUE_WEIGHT_TENSOR_SIZE_DIM_1 = 1,
    parameter int VALUE_WEIGHT_PRECISION_0       = 16,
    parameter int VALUE_WEIGHT_PRECISION_1       = 3,
    parameter int VALUE_WEIGHT_PARALLELISM_DIM_0 = 1,
    parameter int VALUE_WEIGHT_PARALLELISM_DIM_1 = 1,
    parameter int IN_DEPTH = (VALUE_WEIGHT_TENSOR_SIZE_DIM_0 / VALUE_WEIGHT_PARALLELISM_DIM_0)
                           * (VALUE_WEIGHT_TENSOR_SIZE_DIM_1 / VALUE_WEIGHT_PARALLELISM_DIM_1),
    parameter int AWIDTH   = $clog2(IN_DEPTH) + 1
) (
    input  logic clk,
    input  logic rst,
    encoder_layer_1_attention_self_value_weight_sink_if.slave bus
`ifdef ENCODER_LAYER_1_VALUE_WEIGHT_SINK_ERR_EN
    ,
    output logic err
`endif
);
    localparam int DATA_W     = VALUE_WEIGHT_PRECISION_0 * VALUE_WEIGHT_PARALLELISM_DIM_0
                              * VALUE_WEIGHT_PARALLELISM_DIM_1;
    localparam int PTR_W      = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int BANK_WORDS = 1 << PTR_W;

    // Fractional bits are only carried through; they must still fit inside an element.
    if (VALUE_WEIGHT_PRECISION_1 > VALUE_WEIGHT_PRECISION_0) begin : g_bad_frac
        $error("fractional width exceeds element width");
    end

    logic [DATA_W-1:0] mem [2*BANK_WORDS];
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        full_next;
    logic              accept;
    logic              last_beat;
    logic              release_ok;
    logic              addr_ok;
    logic [DATA_W-1:0] rd_q_p0;
    logic [DATA_W-1:0] rd_q_p1;

    assign bus.data_in_ready = !rst && !full[wr_bank];
    assign bus.rd_valid      = !rst && full[rd_bank];
    assign accept            = bus.data_in_valid && bus.data_in_ready;
    assign last_beat         = (wr_ptr == PTR_W'(IN_DEPTH - 1));
    assign release_ok        = bus.rd_release && bus.rd_valid;
    assign addr_ok           = (bus.rd_addr < AWIDTH'(IN_DEPTH));

    // Completion of the write bank and release of the read bank always hit different banks.
    always_comb begin
        full_next = full;
        if (accept && last_beat) full_next[wr_bank] = 1'b1;
        if (release_ok)          full_next[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            full    <= 2'b00;
        end else begin
            full <= full_next;
            if (accept) begin
                if (last_beat) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr  <= wr_ptr + 1'b1;
                end
            end
            if (release_ok) rd_bank <= ~rd_bank;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[{wr_bank, wr_ptr}] <= bus.data_in;
    end

    // Read stage 0: bank RAM output, bank selected at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q_p0 <= '0;
        end else if (bus.rd_ce) begin
            rd_q_p0 <= addr_ok ? mem[{rd_bank, bus.rd_addr[PTR_W-1:0]}] : '0;
        end
    end

    // Read stage 1: output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q_p1 <= '0;
        end else if (bus.rd_ce) begin
            rd_q_p1 <= rd_q_p0;
        end
    end

    assign bus.rd_q = rd_q_p1;

`ifdef ENCODER_LAYER_1_VALUE_WEIGHT_SINK_ERR_EN
    logic              stall_p0;
    logic [DATA_W-1:0] stall_data_p0;
    logic              err_event;

    // A stalled beat must stay valid and unchanged until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) stall_p0 <= 1'b0;
        else     stall_p0 <= bus.data_in_valid && !bus.data_in_ready;
    end

    always_ff @(posedge clk) begin
        stall_data_p0 <= bus.data_in;
    end

    assign err_event = (bus.rd_release && !bus.rd_valid)
                     || (bus.rd_ce && !addr_ok)
                     || (stall_p0 && (!bus.data_in_valid || (bus.data_in != stall_data_p0)));

    always_ff @(posedge clk) begin
        if (rst)            err <= 1'b0;
        else if (err_event) err <= 1'b1;
    end
`endif
endmodule
